mult_scoreboard: RTL
====================

# mult_scoreboard

Synthesizable, parametrised self-checking scoreboard for the multiplier datapath, replacing the fixed-latency testbench check. It queues operand pairs as they enter the compressor tree, computes the golden product per transaction (signed or unsigned), and compares each returned sum/carry pair in order, with no fixed pipeline depth assumed. It keeps pass/fail/unexpected counters, captures the first failure, detects stalls with a timeout, and raises done/grade.

## Interface
- W, 16, operand width; products are 2*W bits
- DEPTH, 8, maximum in-flight transactions (power of two, >=2)
- TIMEOUT, 256, idle cycles with transactions outstanding before timeout fires
- CW, 16, width of every counter and of num_tests
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a run (honoured in IDLE or DONE)
- num_tests  in  CW  transactions to check in this run; sampled on start
- in_valid  in  1  operand pair offered to DUT and scoreboard
- in_ready  out  1  scoreboard can accept (state RUN and queue not full)
- in_a, in_b  in  W  operands
- in_signed  in  1  per-transaction mode: 1 signed, 0 unsigned
- out_valid  in  1  DUT result valid
- out_sum, out_carry  in  2*W  DUT compressor outputs
- pass_cnt, fail_cnt, unexp_cnt  out  CW  saturating counters
- first_fail_a, first_fail_b  out  W  operands of first mismatch
- first_fail_got, first_fail_exp  out  2*W  observed and expected product of first mismatch
- timeout  out  1  sticky; stall detected
- done  out  1  run finished
- grade  out  1  done & fail_cnt==0 & unexp_cnt==0 & !timeout

## Operation
- States IDLE, RUN, DONE. Reset places the block in IDLE with all outputs 0, queue empty, idle counter 0.
- IDLE/DONE --start--> RUN: clear counters, first-fail registers, timeout, done, queue and idle counter; latch num_tests. If num_tests==0, go straight to DONE on the next cycle.
- Push: in_valid & in_ready. The block computes the expected product from the transaction's operands and mode and enqueues it with a and b. Signed mode is the 2W-bit two's-complement product. Unsigned mode is the zero-extended product.
- Check: out_valid in RUN.
  - Queue non-empty: got = (out_sum + out_carry) mod 2^(2W). Compare against the head entry, then pop. Match increments pass_cnt; mismatch increments fail_cnt.
  - First mismatch only: latch a, b, got and exp into the first_fail registers.
  - Queue empty (judged at the cycle start): increment unexp_cnt, no pop. A same-cycle push does not satisfy the check.
  - out_valid is ignored in IDLE/DONE.
- Simultaneous push and pop: both take effect and the occupancy is unchanged. When the queue is full, in_ready stays 0 even if a pop occurs that cycle.
- Checked count = pass_cnt + fail_cnt, kept internally at CW+1 bits. RUN --> DONE when checked reaches num_tests after an update.
- Idle counter:
  - Counts cycles in RUN with the queue non-empty and no out_valid. Resets to 0 on any out_valid or when the queue is empty.
  - Reaching TIMEOUT sets timeout and moves to DONE.
- In DONE: done=1, in_ready=0, and the queue contents are discarded on the next start.
- Counters saturate at 2^CW-1.
- Reset asserted mid-run aborts immediately to IDLE with all state cleared. Transactions in flight are lost.

## Timing
- in_ready is combinational from state and occupancy only; it has no path from in_valid.
- Expected-product computation is registered into the queue entry in the push cycle. The earliest legal check is the cycle after the push, i.e. DUT latency >= 1.
- Counters, first_fail, timeout, done and grade update on the clock edge after the qualifying cycle.
- done rises one cycle after the final check. With num_tests==0, done rises one cycle after start.
- timeout and DONE assert on the edge at which the idle counter reaches TIMEOUT, i.e. TIMEOUT cycles after the last activity.
- start in RUN is ignored.

## Test plan
- W=8, start num_tests=1, push signed a=0xFF b=0x02; two cycles later out_sum=0xFFF0 out_carry=0x000E -> pass_cnt=1, done=1, grade=1.
- Unsigned a=0xFF b=0xFF; return out_sum=0xFE00 out_carry=0x0002 -> fail_cnt=1, first_fail_got=0xFE02, first_fail_exp=0xFE01, first_fail_a=b=0xFF, grade=0.
- DEPTH=4: push 4 with no responses -> in_ready=0 after the 4th push. Then out_valid and in_valid in the same cycle -> one pop, no push; in_ready=1 the next cycle with occupancy 3.
- out_valid with the queue empty in RUN -> unexp_cnt=1 and no change to pass/fail. A simultaneous push is still queued (occupancy 1).
- TIMEOUT=16: push 1, hold out_valid=0 -> timeout=1 and done=1 on the 16th idle cycle, grade=0. A following start clears all counters and flags.
- Assert rst for one cycle after 3 of 5 checks -> all outputs 0, state IDLE, in_ready=0. A new start with num_tests=2 completes normally with pass_cnt=2.

Source files
------------

// File: rtl/mult_scoreboard.sv
// mult_scoreboard: in-order self-checking scoreboard for the multiplier datapath.
// Operand pairs are queued with their golden product when offered. Each DUT
// result (sum + carry) is compared against the oldest queued entry. The block
// keeps saturating pass/fail/unexpected counters, captures the first mismatch,
// and detects stalls.
module mult_scoreboard #(
  parameter int W       = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 256,
  parameter int CW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   num_tests,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_signed,
  input  logic            out_valid,
  input  logic [2*W-1:0]  out_sum,
  input  logic [2*W-1:0]  out_carry,
  output logic [CW-1:0]   pass_cnt,
  output logic [CW-1:0]   fail_cnt,
  output logic [CW-1:0]   unexp_cnt,
  output logic [W-1:0]    first_fail_a,
  output logic [W-1:0]    first_fail_b,
  output logic [2*W-1:0]  first_fail_got,
  output logic [2*W-1:0]  first_fail_exp,
  output logic            timeout,
  output logic            done,
  output logic            grade
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]    count_q, count_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [CW:0]      checked_q, checked_d;
  logic [CW-1:0]    num_q, num_d;
  logic [CW-1:0]    pass_q, pass_d, fail_q, fail_d, unexp_q, unexp_d;
  logic [W-1:0]     ffa_q, ffa_d, ffb_q, ffb_d;
  logic [2*W-1:0]   ffgot_q, ffgot_d, ffexp_q, ffexp_d;
  logic             tmo_q, tmo_d;

  // Queue storage: operands and golden product per in-flight transaction.
  logic [W-1:0]     qa_q   [DEPTH];
  logic [W-1:0]     qb_q   [DEPTH];
  logic [2*W-1:0]   qexp_q [DEPTH];

  logic             push, chk_v, pop, unexp;
  logic [2*W-1:0]   ext_a, ext_b, prod, got;
  logic             match;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // A full queue blocks pushes even if a pop happens in the same cycle.
  assign in_ready = (state_q == RUN) && (count_q != NW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign chk_v    = out_valid & (state_q == RUN);
  // Emptiness is judged on the registered occupancy, so a same-cycle push
  // cannot satisfy a check.
  assign pop      = chk_v & (count_q != '0);
  assign unexp    = chk_v & (count_q == '0);

  // Sign- or zero-extend to 2W; the low 2W bits of the product are then
  // correct for both modes.
  assign ext_a = in_signed ? {{W{in_a[W-1]}}, in_a} : {{W{1'b0}}, in_a};
  assign ext_b = in_signed ? {{W{in_b[W-1]}}, in_b} : {{W{1'b0}}, in_b};
  assign prod  = ext_a * ext_b;
  assign got   = out_sum + out_carry;
  assign match = (got == qexp_q[rd_ptr_q]);

  // Queue write on push; storage needs no reset because the pointers gate it.
  always_ff @(posedge clk) begin
    if (push) begin
      qa_q[wr_ptr_q]   <= in_a;
      qb_q[wr_ptr_q]   <= in_b;
      qexp_q[wr_ptr_q] <= prod;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      idle_q    <= '0;
      checked_q <= '0;
      num_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      unexp_q   <= '0;
      ffa_q     <= '0;
      ffb_q     <= '0;
      ffgot_q   <= '0;
      ffexp_q   <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
      checked_q <= checked_d;
      num_q     <= num_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      unexp_q   <= unexp_d;
      ffa_q     <= ffa_d;
      ffb_q     <= ffb_d;
      ffgot_q   <= ffgot_d;
      ffexp_q   <= ffexp_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state: run control, queue pointers, checking and stall detection.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    idle_d    = idle_q;
    checked_d = checked_q;
    num_d     = num_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    unexp_d   = unexp_q;
    ffa_d     = ffa_q;
    ffb_d     = ffb_q;
    ffgot_d   = ffgot_q;
    ffexp_d   = ffexp_q;
    tmo_d     = tmo_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          idle_d    = '0;
          checked_d = '0;
          num_d     = num_tests;
          pass_d    = '0;
          fail_d    = '0;
          unexp_d   = '0;
          ffa_d     = '0;
          ffb_d     = '0;
          ffgot_d   = '0;
          ffexp_d   = '0;
          tmo_d     = 1'b0;
          state_d   = (num_tests == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
          rd_ptr_d  = rd_ptr_q + AW'(1);
          checked_d = checked_q + (CW+1)'(1);
          if (match) begin
            pass_d = sat_inc(pass_q);
          end else begin
            fail_d = sat_inc(fail_q);
            // fail_cnt still zero means this is the first mismatch of the run.
            if (fail_q == '0) begin
              ffa_d   = qa_q[rd_ptr_q];
              ffb_d   = qb_q[rd_ptr_q];
              ffgot_d = got;
              ffexp_d = qexp_q[rd_ptr_q];
            end
          end
        end
        if (unexp) unexp_d = sat_inc(unexp_q);
        count_d = count_q + NW'(push) - NW'(pop);
        if (out_valid || count_q == '0) idle_d = '0;
        else                            idle_d = idle_q + IW'(1);
        if (pop && checked_d == {1'b0, num_q}) state_d = DONE;
        if (idle_d == IW'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign unexp_cnt      = unexp_q;
  assign first_fail_a   = ffa_q;
  assign first_fail_b   = ffb_q;
  assign first_fail_got = ffgot_q;
  assign first_fail_exp = ffexp_q;
  assign timeout        = tmo_q;
  assign done           = (state_q == DONE);
  assign grade          = done && (fail_q == '0) && (unexp_q == '0) && !tmo_q;

endmodule
